// File: rtl/crtc_pkg.sv
// Shared definitions for the crtc timing generator: register index map,
// reset-default timing values, frame phase type and the sync-width helper.
package crtc_pkg;

  // Register index map for the optional writable register file.
  localparam logic [4:0] R_H_TOTAL    = 5'd0;
  localparam logic [4:0] R_H_DISP     = 5'd1;
  localparam logic [4:0] R_H_SYNC_POS = 5'd2;
  localparam logic [4:0] R_SYNC_W     = 5'd3;
  localparam logic [4:0] R_V_TOTAL    = 5'd4;
  localparam logic [4:0] R_V_ADJ      = 5'd5;
  localparam logic [4:0] R_V_DISP     = 5'd6;
  localparam logic [4:0] R_V_SYNC_POS = 5'd7;
  localparam logic [4:0] R_MAX_RASTER = 5'd9;
  localparam logic [4:0] R_START_HI   = 5'd12;
  localparam logic [4:0] R_START_LO   = 5'd13;

  // Reset-default timing values.
  localparam int unsigned DEF_MA_W       = 14;
  localparam int unsigned DEF_H_TOTAL    = 63;
  localparam int unsigned DEF_H_DISP     = 40;
  localparam int unsigned DEF_H_SYNC_POS = 46;
  localparam int unsigned DEF_H_SYNC_W   = 14;
  localparam int unsigned DEF_V_TOTAL    = 38;
  localparam int unsigned DEF_V_ADJ      = 0;
  localparam int unsigned DEF_V_DISP     = 25;
  localparam int unsigned DEF_V_SYNC_POS = 30;
  localparam int unsigned DEF_V_SYNC_W   = 8;
  localparam int unsigned DEF_MAX_RASTER = 7;
  localparam int unsigned DEF_START_ADDR = 'h3000;

  // Normal character rows versus the vertical-adjust scanlines.
  typedef enum logic {
    PH_ACTIVE = 1'b0,
    PH_ADJUST = 1'b1
  } crtc_phase_e;

  // A programmed sync width of 0 stands for 16.
  function automatic logic [4:0] sync_width(input logic [3:0] w);
    return (w == 4'd0) ? 5'd16 : {1'b0, w};
  endfunction

endpackage

// File: rtl/crtc_sync_width.sv
// Sync pulse stretcher: a loadable 4-bit down-counter holding `active` high
// for the programmed number of steps (characters for hsync, scanlines for
// vsync). A load while already active is ignored (no retrigger).
//   ck16, reset_n : clock, async active-low reset
//   step          : one counting step (character or line end)
//   load          : start a pulse this cycle
//   width         : pulse length in steps, 0 means 16
//   active        : registered sync level
module crtc_sync_width
  import crtc_pkg::*;
(
  input  logic       ck16,
  input  logic       reset_n,
  input  logic       step,
  input  logic       load,
  input  logic [3:0] width,
  output logic       active
);

  logic [3:0] remain;

  // remain counts the steps still to go after the current one.
  always_ff @(posedge ck16 or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      remain <= 4'd0;
    end else if (load && !active) begin
      active <= 1'b1;
      remain <= 4'(sync_width(width) - 5'd1);
    end else if (active && step) begin
      if (remain == 4'd0) begin
        active <= 1'b0;
      end else begin
        remain <= remain - 4'd1;
      end
    end
  end

endmodule

// File: rtl/crtc_timing_gen.sv
// 6845-style video timing generator in the ck16 domain, advancing once per
// character-clock enable. All outputs are registered one ck16 cycle behind
// the counters.
// Optional feature macro: CRTC_REGS_EN -- when defined the timing parameters
// become reset values of registers written through reg_sel/reg_wdata/reg_we;
// otherwise they are constants and the reg_* ports are ignored.
//   ck16, reset_n : 16 MHz clock, async active-low reset
//   cclk_en       : one-cycle pulse per character clock
//   reg_sel/reg_wdata/reg_we : register write port (CRTC_REGS_EN only)
//   hsync, vsync, dispen     : sync and display-enable
//   ma, ra                   : memory address and raster address
module crtc_timing_gen
  import crtc_pkg::*;
#(
  parameter int unsigned MA_W       = DEF_MA_W,
  parameter int unsigned H_TOTAL    = DEF_H_TOTAL,
  parameter int unsigned H_DISP     = DEF_H_DISP,
  parameter int unsigned H_SYNC_POS = DEF_H_SYNC_POS,
  parameter int unsigned H_SYNC_W   = DEF_H_SYNC_W,
  parameter int unsigned V_TOTAL    = DEF_V_TOTAL,
  parameter int unsigned V_ADJ      = DEF_V_ADJ,
  parameter int unsigned V_DISP     = DEF_V_DISP,
  parameter int unsigned V_SYNC_POS = DEF_V_SYNC_POS,
  parameter int unsigned V_SYNC_W   = DEF_V_SYNC_W,
  parameter int unsigned MAX_RASTER = DEF_MAX_RASTER,
  parameter int unsigned START_ADDR = DEF_START_ADDR
) (
  input  logic            ck16,
  input  logic            reset_n,
  input  logic            cclk_en,
  input  logic [4:0]      reg_sel,
  input  logic [7:0]      reg_wdata,
  input  logic            reg_we,
  output logic            hsync,
  output logic            vsync,
  output logic            dispen,
  output logic [MA_W-1:0] ma,
  output logic [4:0]      ra
);

  // Effective timing configuration.
  logic [7:0]      cfg_h_total, cfg_h_disp, cfg_h_sync_pos;
  logic [7:0]      cfg_v_total, cfg_v_disp, cfg_v_sync_pos;
  logic [4:0]      cfg_v_adj, cfg_max_raster;
  logic [3:0]      cfg_h_sync_w, cfg_v_sync_w;
  logic [MA_W-1:0] start_c;

`ifdef CRTC_REGS_EN
  logic [7:0] cfg_start_hi, cfg_start_lo;

  // Register file; writes land immediately, start address is only picked up
  // at the next frame restart.
  always_ff @(posedge ck16 or negedge reset_n) begin
    if (!reset_n) begin
      cfg_h_total    <= 8'(H_TOTAL);
      cfg_h_disp     <= 8'(H_DISP);
      cfg_h_sync_pos <= 8'(H_SYNC_POS);
      cfg_h_sync_w   <= 4'(H_SYNC_W);
      cfg_v_sync_w   <= 4'(V_SYNC_W);
      cfg_v_total    <= 8'(V_TOTAL);
      cfg_v_adj      <= 5'(V_ADJ);
      cfg_v_disp     <= 8'(V_DISP);
      cfg_v_sync_pos <= 8'(V_SYNC_POS);
      cfg_max_raster <= 5'(MAX_RASTER);
      cfg_start_hi   <= 8'(START_ADDR >> 8);
      cfg_start_lo   <= 8'(START_ADDR);
    end else if (reg_we) begin
      case (reg_sel)
        R_H_TOTAL:    cfg_h_total    <= reg_wdata;
        R_H_DISP:     cfg_h_disp     <= reg_wdata;
        R_H_SYNC_POS: cfg_h_sync_pos <= reg_wdata;
        R_SYNC_W: begin
          cfg_v_sync_w <= reg_wdata[7:4];
          cfg_h_sync_w <= reg_wdata[3:0];
        end
        R_V_TOTAL:    cfg_v_total    <= reg_wdata;
        R_V_ADJ:      cfg_v_adj      <= reg_wdata[4:0];
        R_V_DISP:     cfg_v_disp     <= reg_wdata;
        R_V_SYNC_POS: cfg_v_sync_pos <= reg_wdata;
        R_MAX_RASTER: cfg_max_raster <= reg_wdata[4:0];
        R_START_HI:   cfg_start_hi   <= reg_wdata;
        R_START_LO:   cfg_start_lo   <= reg_wdata;
        default: ;
      endcase
    end
  end

  assign start_c = MA_W'({cfg_start_hi, cfg_start_lo});
`else
  logic unused_reg_port;

  assign cfg_h_total    = 8'(H_TOTAL);
  assign cfg_h_disp     = 8'(H_DISP);
  assign cfg_h_sync_pos = 8'(H_SYNC_POS);
  assign cfg_h_sync_w   = 4'(H_SYNC_W);
  assign cfg_v_sync_w   = 4'(V_SYNC_W);
  assign cfg_v_total    = 8'(V_TOTAL);
  assign cfg_v_adj      = 5'(V_ADJ);
  assign cfg_v_disp     = 8'(V_DISP);
  assign cfg_v_sync_pos = 8'(V_SYNC_POS);
  assign cfg_max_raster = 5'(MAX_RASTER);
  assign start_c        = MA_W'(START_ADDR);
  assign unused_reg_port = ^{reg_sel, reg_wdata, reg_we};
`endif

  // Counter state and its next values.
  logic [7:0]      hcc, hcc_n;
  logic [7:0]      vcc, vcc_n;
  logic [4:0]      rc, rc_n;
  logic [MA_W-1:0] row_start, row_start_n;
  crtc_phase_e     phase, phase_n;

  logic h_end_c, hs_load_c, vs_step_c, vs_trig_c;
  logic hs_active, vs_active;
  logic dispen_c;
  logic [MA_W-1:0] ma_c;

  // State register.
  always_ff @(posedge ck16 or negedge reset_n) begin
    if (!reset_n) begin
      hcc       <= 8'd0;
      vcc       <= 8'd0;
      rc        <= 5'd0;
      row_start <= MA_W'(START_ADDR);
      phase     <= PH_ACTIVE;
    end else begin
      hcc       <= hcc_n;
      vcc       <= vcc_n;
      rc        <= rc_n;
      row_start <= row_start_n;
      phase     <= phase_n;
    end
  end

  // Next-state: character, scanline, row and frame stepping.
  always_comb begin
    hcc_n       = hcc;
    vcc_n       = vcc;
    rc_n        = rc;
    row_start_n = row_start;
    phase_n     = phase;
    hs_load_c   = 1'b0;
    vs_trig_c   = 1'b0;
    h_end_c     = (hcc == cfg_h_total);
    vs_step_c   = cclk_en && h_end_c;

    if (cclk_en) begin
      hcc_n     = h_end_c ? 8'd0 : hcc + 8'd1;
      hs_load_c = (hcc_n == cfg_h_sync_pos);

      if (h_end_c) begin
        if (phase == PH_ADJUST) begin
          // Adjust lines reuse rc from 0; restart after V_ADJ of them.
          if (({1'b0, rc} + 6'd1) >= {1'b0, cfg_v_adj}) begin
            vcc_n       = 8'd0;
            rc_n        = 5'd0;
            row_start_n = start_c;
            phase_n     = PH_ACTIVE;
          end else begin
            rc_n = rc + 5'd1;
          end
        end else if (rc == cfg_max_raster) begin
          rc_n        = 5'd0;
          row_start_n = row_start + MA_W'(cfg_h_disp);
          if (vcc == cfg_v_total) begin
            if (cfg_v_adj == 5'd0) begin
              vcc_n       = 8'd0;
              row_start_n = start_c;
            end else begin
              phase_n = PH_ADJUST;
            end
          end else begin
            vcc_n = vcc + 8'd1;
          end
        end else begin
          rc_n = rc + 5'd1;
        end

        // vsync fires entering scanline 0 of the sync row.
        vs_trig_c = (phase_n == PH_ACTIVE) && (rc_n == 5'd0) &&
                    (vcc_n == cfg_v_sync_pos);
      end
    end
  end

  // Output decode from the current counters.
  always_comb begin
    dispen_c = (hcc < cfg_h_disp) && (vcc < cfg_v_disp) && (phase == PH_ACTIVE);
    ma_c     = row_start + MA_W'(hcc);
  end

  crtc_sync_width u_hsync_w (
    .ck16    (ck16),
    .reset_n (reset_n),
    .step    (cclk_en),
    .load    (hs_load_c),
    .width   (cfg_h_sync_w),
    .active  (hs_active)
  );

  crtc_sync_width u_vsync_w (
    .ck16    (ck16),
    .reset_n (reset_n),
    .step    (vs_step_c),
    .load    (vs_trig_c),
    .width   (cfg_v_sync_w),
    .active  (vs_active)
  );

  // Output registers.
  always_ff @(posedge ck16 or negedge reset_n) begin
    if (!reset_n) begin
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      dispen <= 1'b1;
      ma     <= MA_W'(START_ADDR);
      ra     <= 5'd0;
    end else begin
      hsync  <= hs_active;
      vsync  <= vs_active;
      dispen <= dispen_c;
      ma     <= ma_c;
      ra     <= rc;
    end
  end

endmodule

// File: doc/crtc_timing_gen.md
Name: crtc_timing_gen

Overview:
- Parametrised 6845-style video timing generator.
- Produces hsync, vsync, dispen, memory address (ma) and raster address (ra) for the gate array and video fetch path.
- Replaces the static sync/display-enable stimulus used in gate-array benches; also usable in the synthesised core.
- Counters step on a character-clock enable derived from cclk, in the ck16 domain.

Parameters:
- MA_W, 14, width of memory address output.
- H_TOTAL, 63, last horizontal character index (R0).
- H_DISP, 40, displayed characters per line (R1).
- H_SYNC_POS, 46, character index where hsync starts (R2).
- H_SYNC_W, 14, hsync width in characters; 0 means 16.
- V_TOTAL, 38, last character-row index (R4).
- V_ADJ, 0, extra scanlines after the last row (R5).
- V_DISP, 25, displayed character rows (R6).
- V_SYNC_POS, 30, row where vsync starts (R7).
- V_SYNC_W, 8, vsync width in scanlines; 0 means 16.
- MAX_RASTER, 7, last scanline index within a row (R9).
- START_ADDR, 14'h3000, frame start address (R12/R13).

Ports:
- ck16  in  1  16 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- cclk_en  in  1  one-ck16-cycle pulse per character clock.
- reg_sel  in  5  register index (used only with CRTC_REGS_EN).
- reg_wdata  in  8  register write data (used only with CRTC_REGS_EN).
- reg_we  in  1  register write strobe, one ck16 cycle (used only with CRTC_REGS_EN).
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- dispen  out  1  display enable.
- ma  out  MA_W  memory address.
- ra  out  5  raster (scanline-in-row) address.

Behaviour:
- Reset is asynchronous on reset_n low. While in reset: hcc=0, rc=0, vcc=0, adj=0, hsync=0, vsync=0, ma=START_ADDR, row_start=START_ADDR, ra=0, dispen=1 (hcc=0 and vcc=0 is inside the display area).
- Internal state only changes on ck16 edges where cclk_en=1. All outputs are registered and reflect the counters one ck16 cycle after the qualifying edge.
- Horizontal: hcc counts 0..H_TOTAL, then wraps to 0.
- hsync rises when hcc becomes H_SYNC_POS. It stays high for H_SYNC_W characters, counted by a 4-bit width counter. If sync is still active at the hcc wrap, the width counter keeps running.
- Line end (hcc==H_TOTAL): the scanline advances.
  - In normal phase: rc increments. When rc==MAX_RASTER, rc returns to 0 and vcc increments.
  - At vcc==V_TOTAL and rc==MAX_RASTER: if V_ADJ=0, the frame restarts immediately. Otherwise enter adjust phase, counting V_ADJ scanlines with rc continuing from 0, then restart the frame.
  - Frame restart sets vcc=0, rc=0, row_start=START_ADDR.
- vsync rises at the start of line 0 of row V_SYNC_POS. It lasts V_SYNC_W scanlines. It is not retriggered while active.
- dispen=1 iff hcc<H_DISP and vcc<V_DISP and not in adjust phase.
- ma = row_start + hcc, truncated to MA_W bits (wraps modulo 2^MA_W).
- At rc==MAX_RASTER and hcc==H_TOTAL: row_start += H_DISP.
- ra = rc (adjust lines included).
- Simultaneous hsync end and line wrap: both take effect on the same edge.
- Degenerate settings:
  - H_SYNC_POS > H_TOTAL: hsync never asserts.
  - H_DISP > H_TOTAL: dispen is high for the whole line within displayed rows.

Optional Feature:
- CRTC_REGS_EN defined: parameters become reset values of writable registers. reg_we writes reg_wdata to reg_sel.
  - Index map: 0=R0, 1=R1, 2=R2, 3=sync widths (vsync width [7:4], hsync width [3:0]), 4=R4, 5=R5, 6=R6, 7=R7, 9=R9, 12=start high, 13=start low. Other indices are ignored.
  - Writes take effect on the next comparison; no restart.
  - Start address is applied at the next frame restart.
- Not defined: registers are constants. reg_* ports are present but ignored. No write logic is synthesised.

Decomposition:
- Package crtc_pkg: register index constants, reset-default constants, sync-width-zero-means-16 helper function.
- One sub-module, crtc_sync_width: loadable 4-bit down-counter, instanced for both hsync and vsync.

Test Plan:
- Small frame: H_TOTAL=7, H_DISP=4, H_SYNC_POS=5, H_SYNC_W=2, MAX_RASTER=1, V_TOTAL=3, V_DISP=2, V_SYNC_POS=2, V_SYNC_W=2, V_ADJ=0, cclk_en every 16 ck16 → hsync period 8 cclk_en, high 2; frame period 64 cclk_en; dispen high 4 of 8 chars, rows 0-1 only.
- Same frame, check ma → START_ADDR..+3 on line 0; repeats on line 1; START_ADDR+4..+7 on row 1.
- V_ADJ=3 → frame period 88 cclk_en; ra counts 0,1,2 during adjust; dispen=0 throughout adjust.
- H_SYNC_W=0 with H_TOTAL=31 → hsync high exactly 16 characters.
- Reset pulse mid-frame (vcc=2) → all outputs immediately at reset values; counting resumes from hcc=0 after release.
- With CRTC_REGS_EN: write R0=15 mid-line → next wrap occurs at hcc=15; write START_ADDR → ma updates only after frame restart.
